// File: rtl/fir_filter_seq.sv
// fir_filter_seq: runtime-programmable FIR filter with one shared multiplier
// stepped across the taps, one tap per cycle, and valid/ready on both sample ports.
module fir_filter_seq #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 4,
    parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       x_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [ACC_W-1:0]        y_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]       coef_data,
    output logic                    coef_ready
);
    localparam int AW = $clog2(TAPS);
    localparam int PW = DATA_W + COEF_W;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;
    localparam logic [AW-1:0] LP_LAST = AW'(TAPS - 1);

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_x [TAPS];
    logic [COEF_W-1:0] r_h [TAPS];
    logic [ACC_W-1:0]  r_acc;
    logic [AW-1:0]     r_k;
    logic [ACC_W-1:0]  r_y;
    logic              r_outValid;

    logic              w_addrOk;
    logic              w_coefWrite;
    logic signed [PW-1:0] w_prod;
    logic [ACC_W-1:0]  w_sum;

    assign in_ready   = (r_state == S_IDLE);
    assign coef_ready = (r_state == S_IDLE);
    assign y_out      = r_y;
    assign out_valid  = r_outValid;

    // The range check only exists when the address field can encode indices past the last tap.
    generate
        if ((2 ** AW) > TAPS) begin : g_addrChk
            assign w_addrOk = ({1'b0, coef_addr} < (AW + 1)'(TAPS));
        end else begin : g_addrFull
            assign w_addrOk = 1'b1;
        end
    endgenerate

    assign w_coefWrite = coef_we && coef_ready && w_addrOk;
    assign w_prod      = $signed(r_x[r_k]) * $signed(r_h[r_k]);
    assign w_sum       = r_acc + ACC_W'(w_prod);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_k        <= '0;
            r_y        <= '0;
            r_outValid <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                r_x[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int i = TAPS - 1; i > 0; i--) begin
                            r_x[i] <= r_x[i-1];
                        end
                        r_x[0]  <= x_in;
                        r_acc   <= '0;
                        r_k     <= '0;
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc <= w_sum;
                    r_k   <= r_k + AW'(1);
                    if (r_k == LP_LAST) begin
                        r_y        <= w_sum;
                        r_outValid <= 1'b1;
                        r_state    <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Coefficients reset to a ramp 1..TAPS; a write accepted alongside a sample is seen by that sample's MAC pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                r_h[i] <= COEF_W'(i + 1);
            end
        end else if (w_coefWrite) begin
            r_h[coef_addr] <= coef_data;
        end
    end

endmodule

// File: tb/tb_fir_filter_seq.sv
// tb_fir_filter_seq: table-driven and randomized checks of fir_filter_seq against
// a plain-arithmetic FIR model (delay line and coefficient arrays, sum of products).
module tb_fir_filter_seq;
    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int TAPS   = 4;
    localparam int AW     = $clog2(TAPS);
    localparam int ACC_W  = DATA_W + COEF_W + AW;

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] x_in;
    logic              in_valid;
    logic              in_ready;
    logic [ACC_W-1:0]  y_out;
    logic              out_valid;
    logic              out_ready;
    logic              coef_we;
    logic [AW-1:0]     coef_addr;
    logic [COEF_W-1:0] coef_data;
    logic              coef_ready;

    fir_filter_seq #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .reset(reset), .x_in(x_in), .in_valid(in_valid),
        .in_ready(in_ready), .y_out(y_out), .out_valid(out_valid),
        .out_ready(out_ready), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .coef_ready(coef_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int modelX [TAPS];
    int modelH [TAPS];

    typedef struct {
        int     x;
        longint yExp;
    } vec_t;

    vec_t impulseVec [5];
    vec_t stepVec    [4];

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint modelOutput();
        longint s = 0;
        for (int i = 0; i < TAPS; i++) s += longint'(modelX[i]) * longint'(modelH[i]);
        return s;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < TAPS; i++) begin
            modelX[i] = 0;
            modelH[i] = i + 1;
        end
    endtask

    // All tasks start and end just after a falling edge; inputs change there, outputs are sampled there.
    task automatic applyReset();
        reset = 1'b1;
        in_valid = 1'b0;
        coef_we = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        modelReset();
    endtask

    task automatic writeCoef(input int addr, input int data);
        logic [COEF_W-1:0] d;
        d = COEF_W'(data);
        checkOutput("coef_ready in idle", longint'(coef_ready), 1);
        coef_we = 1'b1;
        coef_addr = AW'(addr);
        coef_data = d;
        @(negedge clk);
        coef_we = 1'b0;
        if (addr < TAPS) modelH[addr] = int'($signed(d));
    endtask

    task automatic acceptSample(input int x, input bit doWrite, input int addr, input int data);
        logic [DATA_W-1:0] xv;
        logic [COEF_W-1:0] d;
        xv = DATA_W'(x);
        d = COEF_W'(data);
        checkOutput("in_ready before accept", longint'(in_ready), 1);
        x_in = xv;
        in_valid = 1'b1;
        coef_we = doWrite;
        coef_addr = AW'(addr);
        coef_data = d;
        @(negedge clk);
        in_valid = 1'b0;
        coef_we = 1'b0;
        if (doWrite && addr < TAPS) modelH[addr] = int'($signed(d));
        for (int i = TAPS - 1; i > 0; i--) modelX[i] = modelX[i-1];
        modelX[0] = int'($signed(xv));
    endtask

    // Latency counts rising edges from the acceptance edge until out_valid is seen: TAPS+1.
    task automatic waitResult(input string name, input int edgesSoFar, output longint y);
        int edges = edgesSoFar;
        while (!out_valid && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        checkOutput({name, " latency"}, edges, TAPS + 1);
        y = $signed(y_out);
        checkOutput({name, " vs model"}, y, modelOutput());
    endtask

    task automatic finishHandshake(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput({name, " out_valid cleared"}, longint'(out_valid), 0);
        checkOutput({name, " in_ready back"}, longint'(in_ready), 1);
    endtask

    task automatic applyStimulus();
        longint y;
        longint yHold;

        impulseVec[0] = '{1, 1};
        impulseVec[1] = '{0, 2};
        impulseVec[2] = '{0, 3};
        impulseVec[3] = '{0, 4};
        impulseVec[4] = '{0, 0};
        stepVec[0] = '{3, -3};
        stepVec[1] = '{3, 12};
        stepVec[2] = '{3, 12};
        stepVec[3] = '{3, 33};

        applyReset();
        checkOutput("reset out_valid", longint'(out_valid), 0);
        checkOutput("reset y_out", longint'(y_out), 0);
        checkOutput("reset in_ready", longint'(in_ready), 1);
        checkOutput("reset coef_ready", longint'(coef_ready), 1);

        foreach (impulseVec[i]) begin
            acceptSample(impulseVec[i].x, 1'b0, 0, 0);
            waitResult("impulse", 1, y);
            checkOutput("impulse table", y, impulseVec[i].yExp);
            finishHandshake("impulse");
        end

        writeCoef(0, -1);
        writeCoef(1, 5);
        writeCoef(2, 0);
        writeCoef(3, 7);
        foreach (stepVec[i]) begin
            acceptSample(stepVec[i].x, 1'b0, 0, 0);
            waitResult("step", 1, y);
            checkOutput("step table", y, stepVec[i].yExp);
            finishHandshake("step");
        end

        for (int i = 0; i < TAPS; i++) writeCoef(i, -128);
        for (int i = 0; i < TAPS; i++) begin
            acceptSample(-128, 1'b0, 0, 0);
            waitResult("extreme", 1, y);
            finishHandshake("extreme");
        end
        checkOutput("extreme final no wrap", y, 65536);

        // Backpressure: a sample offered while the result is stalled must not enter the delay line.
        out_ready = 1'b0;
        acceptSample(int'($urandom_range(0, 255)), 1'b0, 0, 0);
        waitResult("backpressure", 1, yHold);
        for (int c = 0; c < 10; c++) begin
            checkOutput("bp y_out stable", longint'($signed(y_out)), yHold);
            checkOutput("bp in_ready low", longint'(in_ready), 0);
            checkOutput("bp out_valid held", longint'(out_valid), 1);
            x_in = 8'd9;
            in_valid = (c == 3);
            @(negedge clk);
        end
        in_valid = 1'b0;
        finishHandshake("backpressure");
        acceptSample(int'($urandom_range(0, 255)), 1'b0, 0, 0);
        waitResult("after bp", 1, y);
        finishHandshake("after bp");

        applyReset();
        acceptSample(1, 1'b0, 0, 0);
        coef_we = 1'b1;
        coef_addr = '0;
        coef_data = 8'd50;
        checkOutput("coef_ready in MAC", longint'(coef_ready), 0);
        @(negedge clk);
        coef_we = 1'b0;
        waitResult("dropped write", 2, y);
        checkOutput("dropped write tap0", y, 1);
        finishHandshake("dropped write");

        for (int i = 0; i < TAPS; i++) writeCoef(i, 9);
        acceptSample(5, 1'b0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        checkOutput("midreset out_valid", longint'(out_valid), 0);
        checkOutput("midreset y_out", longint'(y_out), 0);
        checkOutput("midreset in_ready", longint'(in_ready), 1);
        for (int i = 0; i < 4; i++) begin
            acceptSample(impulseVec[i].x, 1'b0, 0, 0);
            waitResult("post reset impulse", 1, y);
            checkOutput("post reset table", y, impulseVec[i].yExp);
            finishHandshake("post reset");
        end

        for (int n = 0; n < 40; n++) begin
            bit doWrite;
            int delay;
            doWrite = ($urandom_range(0, 2) == 0);
            delay = int'($urandom_range(0, 3));
            out_ready = (delay == 0);
            acceptSample(int'($urandom_range(0, 255)), doWrite,
                         int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 255)));
            waitResult("random", 1, yHold);
            repeat (delay) begin
                @(negedge clk);
                checkOutput("random hold", longint'($signed(y_out)), yHold);
            end
            finishHandshake("random");
        end
    endtask

    initial begin
        reset = 1'b1;
        x_in = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        coef_we = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        @(negedge clk);
        applyStimulus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/fir_filter_seq.md
# fir_filter_seq

Parametrised, runtime-programmable FIR filter for the sample datapath. It replaces the fixed 4-tap, fixed-coefficient filter and adds generic data/coefficient widths, tap count, and a coefficient write port. A single shared multiplier is time-multiplexed across taps (one tap per cycle). Valid/ready handshakes on input and output let it sit between streaming source and sink blocks with backpressure.

## Interface
- DATA_W, 8: signed input sample width.
- COEF_W, 8: signed coefficient width.
- TAPS, 4: number of taps, ≥2.
- ACC_W, DATA_W+COEF_W+$clog2(TAPS): accumulator and output width.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- x_in  in  DATA_W  signed input sample.
- in_valid  in  1  x_in valid.
- in_ready  out  1  filter can accept a sample (high only in IDLE).
- y_out  out  ACC_W  signed filter output, registered.
- out_valid  out  1  y_out valid.
- out_ready  in  1  sink accepts y_out.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(TAPS)  tap index to write.
- coef_data  in  COEF_W  signed coefficient value.
- coef_ready  out  1  coefficient writes accepted (high only in IDLE).

## Operation
- Reset: state IDLE; delay line x[0..TAPS-1] = 0; h[i] = i+1; acc = 0; tap index k = 0; y_out = 0; out_valid = 0. in_ready and coef_ready are decoded from state, so they are 1 from the first cycle after reset.
- States:
  - IDLE: in_ready = 1, coef_ready = 1. On in_valid, at the edge: shift x[i] <= x[i-1], x[0] <= x_in, acc <= 0, k <= 0, go to MAC.
  - MAC: acc <= acc + x[k]*h[k], k <= k+1. When k == TAPS-1: y_out <= final sum (acc + x[k]*h[k]), out_valid <= 1, go to OUT.
  - OUT: hold y_out and out_valid stable. On out_ready: out_valid <= 0, go to IDLE.
- y = Σ x[i]*h[i], where x[0] is the newest sample, including the sample just accepted.
- Arithmetic:
  - All signed two's complement.
  - Each product is sign-extended to ACC_W before accumulation.
  - ACC_W guarantees no overflow for any inputs; no saturation or rounding.
- Coefficient writes:
  - A write is performed when coef_we && coef_ready && coef_addr < TAPS.
  - Writes in MAC or OUT are dropped silently; the source must check coef_ready.
  - A write with coef_addr ≥ TAPS is ignored.
  - If a write and a sample acceptance occur in the same IDLE cycle, the write lands first, so the new coefficient applies to that sample's computation.
- in_valid outside IDLE is ignored and the sample is not consumed.
- Reset in any state (including mid-MAC or OUT with out_valid high) aborts immediately and restores all reset values, including coefficients.

## Timing
- Acceptance edge E0 (IDLE, in_valid = 1). MAC runs on edges E1..E_TAPS. out_valid is high in the cycle after E_TAPS, i.e. TAPS+1 cycles after in_valid was sampled.
- Minimum sample period is TAPS+2 cycles when out_ready is held high (IDLE, then TAPS MAC cycles, then one OUT cycle).
- out_valid deasserts at the edge where out_valid && out_ready. in_ready is high in the following cycle.
- y_out holds its last value after the handshake until the next result is loaded.

## Test plan
- Impulse, TAPS=4, default coefficients, out_ready=1: feed 1, 0, 0, 0, 0 → y_out = 1, 2, 3, 4, 0. Each result has out_valid high exactly 5 cycles after its acceptance edge.
- Coefficient load then step: write h = {-1, 5, 0, 7} in IDLE, then feed 3, 3, 3, 3 → y_out = -3, 12, 12, 33.
- Extremes: write all h = -128, feed four samples of -128 → final y_out = 65536 with no wrap (ACC_W = 18).
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid rises → y_out stable, in_ready = 0, and an in_valid pulse of 9 during that window is not consumed. Release out_ready → IDLE next cycle.
- Dropped write: pulse coef_we (addr 0, data 50) during MAC → coef_ready = 0. The next impulse still yields 1 at tap 0. An out-of-range address is likewise ignored.
- Reset mid-MAC: assert reset in the 2nd MAC cycle after loading custom coefficients → next cycle out_valid = 0, y_out = 0, in_ready = 1. A following impulse yields 1, 2, 3, 4 (coefficients back to default).
